// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pkg
// Description : Shared types and default widths for the immediate extender.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_ext_pkg;

    localparam int c_default_in_w  = 16;
    localparam int c_default_out_w = 32;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_ONES = 2'b10,
        EXT_LUI  = 2'b11
    } ext_mode_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } skid_state_t;

endpackage
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_core
// Description : Combinational immediate extender (ZERO/SIGN/ONES/LUI).
//               LUI decoding is present only when IMM_EXT_LUI_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = c_default_in_w,
    parameter int OUT_W = c_default_out_w
) (
    input  logic [IN_W-1:0]  data,
    input  ext_mode_t        mode,
    output logic [OUT_W-1:0] result
);

    generate
        if (OUT_W < IN_W) begin : g_width_check
            $error("imm_ext_core: OUT_W must be >= IN_W");
        end
    endgenerate

    // Ones above the immediate field; all-zero when the widths match.
    localparam logic [OUT_W-1:0] c_pad_mask = ~(OUT_W'({IN_W{1'b1}}));

    logic [OUT_W-1:0] w_zext;

    assign w_zext = OUT_W'(data);

    always_comb begin
        result = w_zext;
        case (mode)
            EXT_SIGN: if (data[IN_W-1]) result = w_zext | c_pad_mask;
            EXT_ONES: result = w_zext | c_pad_mask;
`ifdef IMM_EXT_LUI_EN
            EXT_LUI:  result = w_zext << (OUT_W - IN_W);
`endif
            default:  result = w_zext;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pipe
// Description : Immediate extender behind a 2-entry skid buffer with
//               valid/ready handshakes. LUI mode enabled by IMM_EXT_LUI_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = c_default_in_w,
    parameter int OUT_W = c_default_out_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    skid_state_t      r_state;
    skid_state_t      w_state_nxt;
    logic             r_in_ready;
    logic [OUT_W-1:0] r_head;
    logic [OUT_W-1:0] r_tail;
    logic [OUT_W-1:0] w_ext;
    logic             w_accept;
    logic             w_drain;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .data   (in_data),
        .mode   (ext_mode_t'(in_mode)),
        .result (w_ext)
    );

    assign w_accept  = in_valid && r_in_ready;
    assign w_drain   = (r_state != EMPTY) && out_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_head;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_accept) w_state_nxt = ONE;
            ONE: begin
                if (w_accept && !w_drain)      w_state_nxt = TWO;
                else if (!w_accept && w_drain) w_state_nxt = EMPTY;
            end
            TWO:     if (w_drain) w_state_nxt = ONE;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // in_ready is registered from the next state so out_ready never reaches it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != TWO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_state)
                EMPTY: if (w_accept) r_head <= w_ext;
                ONE: begin
                    if (w_accept && w_drain) r_head <= w_ext;
                    else if (w_accept)       r_tail <= w_ext;
                end
                TWO:     if (w_drain) r_head <= r_tail;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 Parameter IN_W, default 16, meaning the immediate input width in bits.
REQ-002 Parameter OUT_W, default 32, meaning the extended output width in bits; OUT_W >= IN_W, checked by an elaboration-time assertion.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: the producer offers in_data/in_mode.
REQ-006 Port in_ready, output, 1 bit: the block can accept; transfer occurs when in_valid && in_ready.
REQ-007 Port in_data, input, IN_W bits: the immediate field.
REQ-008 Port in_mode, input, 2 bits: the extension mode (00 ZERO, 01 SIGN, 10 ONES, 11 LUI).
REQ-009 Port out_valid, output, 1 bit: out_data holds a result.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts; transfer occurs when out_valid && out_ready.
REQ-011 Port out_data, output, OUT_W bits: the extended result.

Function
REQ-012 ZERO mode SHALL output {(OUT_W-IN_W) zeros, in_data}.
REQ-013 SIGN mode SHALL output {(OUT_W-IN_W) copies of in_data[IN_W-1], in_data}.
REQ-014 ONES mode SHALL output {(OUT_W-IN_W) ones, in_data}.
REQ-015 LUI mode SHALL output in_data placed in bits [OUT_W-1:OUT_W-IN_W], with zeros below; when OUT_W == IN_W it equals in_data.
REQ-016 Extension SHALL be computed at acceptance, and the result registered.
REQ-017 The block SHALL be a 2-entry skid buffer with states EMPTY, ONE and TWO.
REQ-018 The transition rules SHALL be:
- EMPTY: on accept, go to ONE.
- ONE: on accept only, go to TWO; on drain only, go to EMPTY; on accept and drain together, stay in ONE.
- TWO: on drain, go to ONE.
REQ-019 in_ready SHALL be 1 exactly when the state is not TWO, driven from a register with no combinational path from out_ready.
REQ-020 out_valid SHALL be 1 exactly when the state is not EMPTY; out_data SHALL be the oldest entry.
REQ-021 Latency from accept to out_valid SHALL be 1 cycle; sustained throughput SHALL be 1 item per cycle when out_ready is held at 1.
REQ-022 Order SHALL be FIFO; no item is dropped or duplicated.
REQ-023 While out_valid=1 && out_ready=0, out_data SHALL remain stable.
REQ-024 In state TWO, an in_valid SHALL be ignored and in_data SHALL NOT be sampled.

Reset
REQ-025 Assertion of rst_n=0 SHALL immediately force the state to EMPTY, out_valid=0, in_ready=0 and out_data=0, regardless of the clock.
REQ-026 in_ready SHALL go to 1 on the first rising clk edge after rst_n deasserts.
REQ-027 Items in flight when reset asserts mid-operation SHALL be discarded.

Configuration
REQ-028 The macro IMM_EXT_LUI_EN SHALL control LUI mode.
- With IMM_EXT_LUI_EN defined: mode 11 performs LUI per REQ-015.
- With IMM_EXT_LUI_EN undefined: mode 11 is decoded as ZERO, and no LUI logic is synthesised.

Structure
REQ-029 A shared package imm_ext_pkg SHALL hold:
- the ext_mode_t enum (EXT_ZERO, EXT_SIGN, EXT_ONES, EXT_LUI);
- the skid state enum;
- the default width constants.
REQ-030 The combinational extender SHALL be a sub-module imm_ext_core (parameters IN_W and OUT_W; ports data, mode, result), instantiated once at the input side.

Verification
REQ-031 The bench SHALL cover, with defaults and LUI enabled, these directed scenarios:
- Sign and zero: SIGN with in_data=16'h8001 -> 32'hFFFF8001 one cycle later; ZERO with 16'h8001 -> 32'h00008001.
- Ones and LUI: ONES with 16'h1234 -> 32'hFFFF1234; LUI with 16'h1234 -> 32'h12340000; rebuilt without IMM_EXT_LUI_EN, the same stimulus -> 32'h00001234.
- Backpressure: out_ready=0 while pushing A, B, C -> in_ready drops after B, C is not accepted, out_data holds A; out_ready=1 -> A, B, C are delivered in order.
- Streaming: in_valid=out_ready=1 for 100 cycles with random data -> 100 outputs, 1 per cycle, matching the reference model.
- Reset mid-operation: rst_n=0 pulse in state TWO between clock edges -> out_valid=0 immediately, and after release the next item alone appears.
- Parameter sweep: IN_W=12, OUT_W=32, SIGN with 12'h800 -> 32'hFFFFF800; IN_W=OUT_W=16, SIGN with 16'h8000 -> 16'h8000.
